// File: rtl/xcorr_scheduler_if.sv
// Bundle of the scheduler's request/result signals and the shared
// correlation-engine handshake. The master side requests measurements and
// plays the engine; the slave side is the scheduler itself.
interface xcorr_scheduler_if #(
  parameter int LAG_W = 16,
  parameter int VAL_W = 32
);
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic                    eng_start;
  logic                    eng_sel;
  logic                    eng_rdy;
  logic [LAG_W-1:0]        eng_lag;
  logic [VAL_W-1:0]        eng_peak;
  logic [LAG_W-1:0]        lag_a;
  logic [LAG_W-1:0]        lag_b;
  logic [VAL_W-1:0]        peak_a;
  logic [VAL_W-1:0]        peak_b;
  logic signed [LAG_W:0]   tdoa;

  modport master (
    output start, eng_rdy, eng_lag, eng_peak,
    input  busy, done, err, eng_start, eng_sel,
           lag_a, lag_b, peak_a, peak_b, tdoa
  );

  modport slave (
    input  start, eng_rdy, eng_lag, eng_peak,
    output busy, done, err, eng_start, eng_sel,
           lag_a, lag_b, peak_a, peak_b, tdoa
  );
endinterface

// File: rtl/xcorr_scheduler.sv
// Sequences one A+B cross-correlation measurement on a shared engine:
// run channel A, capture its result, run channel B, capture, then register
// the time difference of arrival tdoa = lag_b - lag_a.
// Optional feature macro XCORR_TIMEOUT_EN: adds a wait-cycle counter that
// aborts a stuck engine wait after TIMEOUT cycles and flags err.
module xcorr_scheduler #(
  parameter int LAG_W   = 16,
  parameter int VAL_W   = 32,
  parameter int TIMEOUT = 8192
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  xcorr_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, RUN_A, WAIT_A, RUN_B, WAIT_B, CALC, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [LAG_W-1:0]       lag_a_q, lag_a_d, lag_b_q, lag_b_d;
  logic [VAL_W-1:0]       peak_a_q, peak_a_d, peak_b_q, peak_b_d;
  logic signed [LAG_W:0]  tdoa_q, tdoa_d;
  logic                   busy, done, eng_start, eng_sel;

`ifdef XCORR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;
  logic             err_q, err_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Wait-cycle counter: zeroed while launching a channel, counts in WAIT_*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ena) begin
      if (state_q == RUN_A || state_q == RUN_B)
        cnt_q <= '0;
      else if ((state_q == WAIT_A || state_q == WAIT_B) && !timeout_hit)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Timeout flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      err_q <= 1'b0;
    else if (ena) err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Next-state, result capture and Moore outputs.
  always_comb begin
    state_d   = state_q;
    lag_a_d   = lag_a_q;
    lag_b_d   = lag_b_q;
    peak_a_d  = peak_a_q;
    peak_b_d  = peak_b_q;
    tdoa_d    = tdoa_q;
    busy      = 1'b1;
    done      = 1'b0;
    eng_start = 1'b0;
    eng_sel   = 1'b0;
`ifdef XCORR_TIMEOUT_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          state_d = RUN_A;
`ifdef XCORR_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      RUN_A: begin
        // Gated by ena so a frozen RUN_A never repeats the engine pulse.
        eng_start = ena;
        state_d   = WAIT_A;
      end
      WAIT_A: begin
        if (bus.eng_rdy) begin
          lag_a_d  = bus.eng_lag;
          peak_a_d = bus.eng_peak;
          state_d  = RUN_B;
        end
`ifdef XCORR_TIMEOUT_EN
        else if (timeout_hit) begin
          err_d    = 1'b1;
          lag_a_d  = '0;
          peak_a_d = '0;
          state_d  = CALC;
        end
`endif
      end
      RUN_B: begin
        eng_start = ena;
        eng_sel   = 1'b1;
        state_d   = WAIT_B;
      end
      WAIT_B: begin
        eng_sel = 1'b1;
        if (bus.eng_rdy) begin
          lag_b_d  = bus.eng_lag;
          peak_b_d = bus.eng_peak;
          state_d  = CALC;
        end
`ifdef XCORR_TIMEOUT_EN
        else if (timeout_hit) begin
          err_d    = 1'b1;
          lag_b_d  = '0;
          peak_b_d = '0;
          state_d  = CALC;
        end
`endif
      end
      CALC: begin
        eng_sel = 1'b1;
        // Zero-extend both lags by one bit so the difference cannot overflow.
        tdoa_d  = $signed({1'b0, lag_b_q}) - $signed({1'b0, lag_a_q});
        state_d = DONE;
      end
      DONE: begin
        done    = ena;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; everything holds while ena is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lag_a_q  <= '0;
      lag_b_q  <= '0;
      peak_a_q <= '0;
      peak_b_q <= '0;
      tdoa_q   <= '0;
    end else if (ena) begin
      state_q  <= state_d;
      lag_a_q  <= lag_a_d;
      lag_b_q  <= lag_b_d;
      peak_a_q <= peak_a_d;
      peak_b_q <= peak_b_d;
      tdoa_q   <= tdoa_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.eng_start = eng_start;
  assign bus.eng_sel   = eng_sel;
  assign bus.lag_a     = lag_a_q;
  assign bus.lag_b     = lag_b_q;
  assign bus.peak_a    = peak_a_q;
  assign bus.peak_b    = peak_b_q;
  assign bus.tdoa      = tdoa_q;

endmodule

// File: tb/tb_xcorr_scheduler.sv
// Self-checking bench for xcorr_scheduler. Each measurement is scripted as a
// timeline (start, engine responses, optional freeze or reset); the expected
// outputs for every cycle follow from that timeline, and one compare process
// checks them on the falling edge.
module tb_xcorr_scheduler;
  localparam int LAG_W   = 16;
  localparam int VAL_W   = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  always #5 clk = ~clk;

  xcorr_scheduler_if #(.LAG_W(LAG_W), .VAL_W(VAL_W)) bus ();

  xcorr_scheduler #(.LAG_W(LAG_W), .VAL_W(VAL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  // Expected outputs for the current cycle.
  logic                  chk_en = 1'b0;
  logic                  e_busy, e_done, e_err, e_start, e_sel;
  logic [LAG_W-1:0]      m_lag_a, m_lag_b;
  logic [VAL_W-1:0]      m_peak_a, m_peak_b;
  logic signed [LAG_W:0] m_tdoa;

  // Observed pulse counts, used for per-measurement literal checks.
  int n_eng_start = 0;
  int n_done      = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_busy = 0; e_done = 0; e_err = 0; e_start = 0; e_sel = 0;
    m_lag_a = '0; m_lag_b = '0; m_peak_a = '0; m_peak_b = '0; m_tdoa = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the expectation set for this cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      bus.busy,      e_busy);
      check("done",      bus.done,      e_done);
      check("err",       bus.err,       e_err);
      check("eng_start", bus.eng_start, e_start);
      check("eng_sel",   bus.eng_sel,   e_sel);
      check("lag_a",     bus.lag_a,     m_lag_a);
      check("lag_b",     bus.lag_b,     m_lag_b);
      check("peak_a",    bus.peak_a,    m_peak_a);
      check("peak_b",    bus.peak_b,    m_peak_b);
      check("tdoa",      bus.tdoa,      m_tdoa);
    end
  end

  // Pulse counters.
  always @(negedge clk) begin
    if (bus.eng_start === 1'b1) n_eng_start++;
    if (bus.done === 1'b1)      n_done++;
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      ena          = 1'b1;
      bus.start    = 1'b0;
      bus.eng_rdy  = 1'($urandom_range(0, 1));
      bus.eng_lag  = LAG_W'($urandom);
      bus.eng_peak = VAL_W'($urandom);
      e_busy = 0; e_done = 0; e_start = 0; e_sel = 0;
      tick();
    end
  endtask

  // One measurement. Cycle 0 presents start; WAIT_A spans cycles 2..ca with
  // da idle cycles, then fz frozen cycles (ena low, eng_rdy high), then the
  // capture at ca. RUN_B is ca+1, WAIT_B ca+2..cb with capture at cb,
  // CALC cb+1, DONE cb+2. ab >= 0 asserts reset in that cycle instead.
  task automatic run_txn(input int da, input int db, input int fz, input int ab,
                         input logic [LAG_W-1:0] la, input logic [VAL_W-1:0] pa,
                         input logic [LAG_W-1:0] lb, input logic [VAL_W-1:0] pb);
    int ca, cb, last, d;
    logic in_w, frz;
    ca   = 2 + da + fz;
    cb   = ca + 2 + db;
    last = cb + 2;
    for (int k = 0; k <= last; k++) begin
      if (k == ab) begin
        rst = 1'b1; bus.start = 1'b0; bus.eng_rdy = 1'b0; ena = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        txn_no++;
        $display("txn %0d reset at cycle %0d", txn_no, ab);
        return;
      end
      frz  = (k >= 2 + da) && (k < ca);
      in_w = ((k >= 2) && (k <= ca)) || ((k >= ca + 2) && (k <= cb));
      ena  = !frz;
      bus.start = (k == 0) || (k == 2) || (k >= 1 && $urandom_range(0, 3) == 0);
      if (k == ca) begin
        bus.eng_rdy = 1'b1; bus.eng_lag = la; bus.eng_peak = pa;
      end else if (k == cb) begin
        bus.eng_rdy = 1'b1; bus.eng_lag = lb; bus.eng_peak = pb;
      end else begin
        if (frz || k == 1 || k == ca + 1)
          bus.eng_rdy = 1'b1;
        else if (in_w)
          bus.eng_rdy = 1'b0;
        else
          bus.eng_rdy = 1'($urandom_range(0, 1));
        bus.eng_lag  = LAG_W'($urandom);
        bus.eng_peak = VAL_W'($urandom);
      end
      e_busy  = (k >= 1);
      e_start = (k == 1) || (k == ca + 1);
      e_sel   = (k >= ca + 1) && (k <= cb + 1);
      e_done  = (k == last);
      if (k == 1) e_err = 1'b0;
      if (k == ca + 1) begin m_lag_a = la; m_peak_a = pa; end
      if (k == cb + 1) begin m_lag_b = lb; m_peak_b = pb; end
      if (k == cb + 2) begin
        d = int'(lb) - int'(la);
        m_tdoa = d[LAG_W:0];
      end
      tick();
    end
    ena = 1'b1; bus.start = 1'b0; bus.eng_rdy = 1'b0;
    e_busy = 0; e_done = 0; e_start = 0; e_sel = 0;
    txn_no++;
    $display("txn %0d da=%0d db=%0d fz=%0d lag_a=%0d lag_b=%0d tdoa=%0d",
             txn_no, da, db, fz, la, lb, bus.tdoa);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, dcyc;
    rst = 1'b1; ena = 1'b1;
    bus.start = 1'b0; bus.eng_rdy = 1'b0; bus.eng_lag = '0; bus.eng_peak = '0;
    model_reset();
    #1;
    chk_en = 1'b1;
    tick(); tick();
    check("reset_busy", bus.busy, 0);
    rst = 1'b0;
    idle(3);
    check("no_start_after_reset", n_eng_start, 0);

    // Nominal measurement: 10 wait cycles per channel, lags 120 then 95.
    s0 = n_eng_start; d0 = n_done;
    run_txn(10, 10, 0, -1, 16'd120, 32'd5000, 16'd95, 32'd4000);
    check("lit_lag_a", bus.lag_a, 120);
    check("lit_lag_b", bus.lag_b, 95);
    check("lit_tdoa_neg", bus.tdoa, -25);
    check("lit_done_pulses", n_done - d0, 1);
    check("lit_eng_starts", n_eng_start - s0, 2);
    check("lit_err", bus.err, 0);
    idle(2);

    // Extremes of the lag range.
    run_txn(0, 0, 0, -1, 16'd0, 32'd1, 16'hFFFF, 32'hFFFF_FFFF);
    check("lit_tdoa_max", bus.tdoa, 65535);
    idle(1);
    run_txn(1, 2, 0, -1, 16'hFFFF, 32'd7, 16'd0, 32'd9);
    check("lit_tdoa_min", bus.tdoa, -65535);
    idle(1);

    // Five frozen cycles in WAIT_A with eng_rdy high.
    run_txn(3, 2, 5, -1, 16'd777, 32'd31, 16'd800, 32'd32);
    check("lit_freeze_lag_a", bus.lag_a, 777);
    check("lit_freeze_tdoa", bus.tdoa, 23);
    idle(2);

    // Reset in WAIT_B (ca = 6, WAIT_B starts at 8), then a clean run.
    run_txn(4, 6, 0, 10, 16'd11, 32'd12, 16'd13, 32'd14);
    check("lit_abort_busy", bus.busy, 0);
    check("lit_abort_lag_a", bus.lag_a, 0);
    s0 = n_eng_start; d0 = n_done;
    run_txn(2, 3, 0, -1, 16'd300, 32'd301, 16'd310, 32'd302);
    check("lit_post_reset_starts", n_eng_start - s0, 2);
    check("lit_post_reset_done", n_done - d0, 1);
    check("lit_post_reset_tdoa", bus.tdoa, 10);
    idle(2);

    // Randomized measurements.
    for (int t = 0; t < 30; t++) begin
      run_txn($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 3), -1,
              LAG_W'($urandom), VAL_W'($urandom), LAG_W'($urandom), VAL_W'($urandom));
      idle($urandom_range(0, 3));
    end

    // Engine never answers.
    chk_en = 1'b0;
    bus.start = 1'b1; bus.eng_rdy = 1'b0; ena = 1'b1;
    s0 = n_eng_start;
    tick();
    bus.start = 1'b0;
    dcyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 && dcyc < 0) dcyc = k;
      tick();
    end
`ifdef XCORR_TIMEOUT_EN
    check("timeout_done_cycle", dcyc, 19);
    check("timeout_err", bus.err, 1);
    check("timeout_lag_a", bus.lag_a, 0);
    check("timeout_peak_a", bus.peak_a, 0);
    check("timeout_busy", bus.busy, 0);
    check("timeout_eng_starts", n_eng_start - s0, 1);
`else
    check("stuck_busy", bus.busy, 1);
    check("stuck_no_done", dcyc, -1);
    check("stuck_err", bus.err, 0);
    check("stuck_eng_starts", n_eng_start - s0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
